// File: rtl/norm_unit.sv
// Leading zero/one counter with normaliser. A 4-bit-per-cycle scan counts the
// leading bits, then the latched operand is shifted left by that count.
module norm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        flush,
  input  logic [31:0] Indata,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count,
  output logic [31:0] norm_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] norm_q, norm_d;

  logic [3:0]  nib;
  logic [1:0]  nib_lz;
  logic [5:0]  final_cnt;
  logic        finish;

  // Leading-zero count of the top nibble; only meaningful when it is nonzero.
  always_comb begin
    nib = work_q[31:28];
    casez (nib)
      4'b1???: nib_lz = 2'd0;
      4'b01??: nib_lz = 2'd1;
      4'b001?: nib_lz = 2'd2;
      default: nib_lz = 2'd3;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    norm_d    = norm_q;
    final_cnt = cnt_q;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = Indata;
          work_d  = mode ? ~Indata : Indata;
          cnt_d   = 6'd0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (nib == 4'd0) begin
          if (cnt_q + 6'd4 < 6'd32) begin
            work_d = {work_q[27:0], 4'd0};
            cnt_d  = cnt_q + 6'd4;
          end else begin
            final_cnt = 6'd32;
            finish    = 1'b1;
          end
        end else begin
          final_cnt = cnt_q + {4'd0, nib_lz};
          finish    = 1'b1;
        end

        if (finish) begin
          cnt_d   = final_cnt;
          count_d = final_cnt;
          norm_d  = (final_cnt == 6'd32) ? 32'd0 : (op_q << final_cnt);
          state_d = DONE;
        end
      end

      DONE: begin
        // Unconditional return; neither start nor flush is looked at here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 32'd0;
      work_q  <= 32'd0;
      cnt_q   <= 6'd0;
      count_q <= 6'd0;
      norm_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      norm_q  <= norm_d;
    end
  end

  // Status decodes straight from state, so reset clears them without a clock.
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign count       = count_q;
  assign norm_result = norm_q;

endmodule

// File: doc/norm_unit.md
NORM_UNIT -- requirements
Module: norm_unit

Interface
REQ-001 Ports SHALL be, one per line, name direction width meaning:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = count leading zeros (CLZ); 1 = count leading ones (CLO); sampled with start.
- flush  input  1  pipeline flush; aborts the operation in progress.
- Indata  input  32  operand; sampled with start.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle result-valid pulse.
- count  output  6  leading zero/one count, 0..32.
- norm_result  output  32  latched operand shifted left logically by count.
REQ-002 No parameters; data width SHALL be fixed at 32.

Function
REQ-003 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-004 In IDLE, start=1 with flush=0 SHALL, at the edge:
- latch Indata into op_q;
- load the work register with Indata when mode=0, or ~Indata when mode=1;
- clear the internal counter;
- enter SCAN.
REQ-005 Each SCAN edge SHALL examine work[31:28]:
- if zero and counter+4 < 32: shift work left 4 and add 4 to the counter;
- if zero and counter+4 = 32: set counter to 32 and go to DONE;
- if nonzero: add that nibble's leading-zero count (0..3) to the counter and go to DONE.
REQ-006 Number of SCAN edges S SHALL be floor(lz/4)+1 for lz<32 and 8 for lz=32, where lz is the leading zero count of the work operand.
REQ-007 On entering DONE:
- count SHALL be registered from the final counter value;
- norm_result SHALL be registered as op_q << count, zero-filled, and 0 when count=32;
- done SHALL be 1 for exactly the DONE cycle.
REQ-008 The FSM SHALL go from DONE to IDLE unconditionally at the next edge; start asserted during the DONE cycle SHALL be ignored.
REQ-009 busy SHALL be 1 exactly while in SCAN; done and busy SHALL never be 1 together.
REQ-010 start asserted outside IDLE SHALL be ignored; it SHALL neither be queued nor restart the operation.
REQ-011 count and norm_result SHALL hold their last values until the next DONE, including while IDLE and SCAN.
REQ-012 flush=1 in SCAN SHALL return the FSM to IDLE at the next edge; done SHALL not pulse and count/norm_result SHALL be left unchanged.
REQ-013 flush=1 in DONE SHALL not cancel the done pulse already asserted.
REQ-014 flush and start asserted together in IDLE: flush SHALL win and the FSM SHALL stay in IDLE.
REQ-015 Latency, measured from the edge E0 that samples start: done SHALL be high in the cycle after edge E0+S.

Reset
REQ-016 rst=1 SHALL immediately, without waiting for clk:
- force state IDLE;
- clear busy, done, count, norm_result, op_q, the work register and the counter to 0.
REQ-017 rst asserted mid-SCAN SHALL abort the operation with no done pulse; after rst deasserts, the first accepted start SHALL behave as from power-up.

Verification
REQ-018 Indata=0x0001_0000, mode=0 -> S=4; done after edge E0+4; count=15; norm_result=0x8000_0000.
REQ-019 Indata=0x0000_0000, mode=0 -> S=8; count=32; norm_result=0x0000_0000; busy high for 8 cycles.
REQ-020 Indata=0xFFFF_FFF5, mode=1 -> S=8; count=28; norm_result=0x5000_0000.
REQ-021 Indata=0x8000_0000, mode=0 -> S=1; count=0; norm_result=0x8000_0000; a second start pulsed during SCAN is ignored, so exactly one done pulse.
REQ-022 After a completed CLZ of 0x0000_00FF (count=24), start Indata=0, then flush on the 3rd SCAN cycle -> IDLE next edge; no done; count stays 24.
REQ-023 rst pulsed asynchronously (mid-cycle) during SCAN -> busy=0 and count=0 immediately; no done; next start of 0x0F00_0000 mode=0 -> count=4, norm_result=0xF000_0000.
